hd_dma_controller: RTL and testbench

Block-transfer engine directly upstream of the hard-disk storage block. It drives the disk's track/trackPos/writeData/hdFlag inputs and consumes its registered readData. It moves a run of 32-bit words between the disk and data memory in either direction, on a single start command from the CPU-side control logic. One word moves every 2 cycles; busy/done status is reported back to the CPU side.

---
 rtl/hd_dma_controller_pkg.sv | 21 ++
 rtl/hd_dma_controller_addr_stepper.sv | 79 +++++++
 rtl/hd_dma_controller.sv | 156 +++++++++++++++
 tb/tb_hd_dma_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hd_dma_controller_pkg.sv
// Shared definitions for the hard-disk DMA controller: state encoding,
// transfer direction constants and track geometry helper.
package hd_dma_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SRC_ADDR  = 2'd1,
        ST_DST_WRITE = 2'd2,
        ST_DONE      = 2'd3
    } state_e;

    localparam logic DIR_DISK2MEM = 1'b0;
    localparam logic DIR_MEM2DISK = 1'b1;

    // Words per track for a disk of disk_words split evenly into tracks.
    function automatic int unsigned track_size(input int unsigned disk_words,
                                               input int unsigned tracks);
        return disk_words / tracks;
    endfunction

endpackage

// File: rtl/hd_dma_controller_addr_stepper.sv
// Address/count bookkeeping for one transfer: loads the starting disk
// track/pos, memory byte address and word count, then advances all of
// them by one word per step, wrapping the position into the next track.
module hd_addr_stepper #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TRACKS     = 4,
    parameter int unsigned TRACK_SIZE = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [DATA_WIDTH-1:0] track_i,
    input  logic [DATA_WIDTH-1:0] pos_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] count_i,
    output logic [DATA_WIDTH-1:0] track_o,
    output logic [DATA_WIDTH-1:0] pos_o,
    output logic [DATA_WIDTH-1:0] addr_o,
    output logic                  last_o,
    output logic                  overflow_o
);

    logic [DATA_WIDTH-1:0] track_q, track_d;
    logic [DATA_WIDTH-1:0] pos_q, pos_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] remaining_q, remaining_d;
    logic                  at_track_end;

    assign at_track_end = (pos_q == DATA_WIDTH'(TRACK_SIZE - 1));

    // Next-state: load a new command, or advance one word with track wrap.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        track_d     = track_q;
        pos_d       = pos_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        if (load_i) begin
            track_d     = track_i;
            pos_d       = pos_i;
            addr_d      = addr_i;
            remaining_d = count_i;
        end else if (step_i) begin
            remaining_d = remaining_q - DATA_WIDTH'(1);
            addr_d      = addr_q + DATA_WIDTH'(4);
            if (at_track_end) begin
                pos_d   = '0;
                track_d = track_q + DATA_WIDTH'(1);
            end else begin
                pos_d   = pos_q + DATA_WIDTH'(1);
            end
        end
    end

    // Counter registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (!rst_n) begin
            track_q     <= '0;
            pos_q       <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
        end else begin
            track_q     <= track_d;
            pos_q       <= pos_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
        end
    end

    assign track_o    = track_q;
    assign pos_o      = pos_q;
    assign addr_o     = addr_q;
    assign last_o     = (remaining_q == DATA_WIDTH'(1));
    // Stepping now would push the position past the final track.
    assign overflow_o = at_track_end && (track_q == DATA_WIDTH'(TRACKS - 1));

endmodule

// File: rtl/hd_dma_controller.sv
// Block-transfer engine between the hard-disk block and data memory.
// Each word takes two cycles: present the source address, then write the
// registered read data to the destination.
module hd_dma_controller
    import hd_dma_controller_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DISK_WORDS = 1024,
    parameter int unsigned TRACKS     = 4,
    parameter int unsigned MAX_COUNT  = 1024
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  dir,
    input  logic [DATA_WIDTH-1:0] cmdTrack,
    input  logic [DATA_WIDTH-1:0] cmdPos,
    input  logic [DATA_WIDTH-1:0] cmdMemAddr,
    input  logic [DATA_WIDTH-1:0] cmdCount,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] hdTrack,
    output logic [DATA_WIDTH-1:0] hdTrackPos,
    output logic [DATA_WIDTH-1:0] hdWriteData,
    output logic                  hdFlag,
    input  logic [DATA_WIDTH-1:0] hdReadData,
    output logic [DATA_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWriteData,
    output logic                  memWrite,
    input  logic [DATA_WIDTH-1:0] memReadData
);

    localparam int unsigned TRACK_SIZE = track_size(DISK_WORDS, TRACKS);

    state_e                state_q, state_d;
    logic                  dir_q, dir_d;
    logic                  error_q, error_d;
    logic                  load, step;
    logic                  cmd_illegal;
    logic [DATA_WIDTH-1:0] cur_track, cur_pos, cur_addr;
    logic                  last_word, overflow;

    assign cmd_illegal = (cmdCount > DATA_WIDTH'(MAX_COUNT))
                      || (cmdTrack >= DATA_WIDTH'(TRACKS))
                      || (cmdPos >= DATA_WIDTH'(TRACK_SIZE))
                      || (cmdMemAddr[1:0] != 2'b00);

    hd_addr_stepper #(
        .DATA_WIDTH (DATA_WIDTH),
        .TRACKS     (TRACKS),
        .TRACK_SIZE (TRACK_SIZE)
    ) u_stepper (
        .clk        (clock),
        .rst_n      (reset_n),
        .load_i     (load),
        .step_i     (step),
        .track_i    (cmdTrack),
        .pos_i      (cmdPos),
        .addr_i     (cmdMemAddr),
        .count_i    (cmdCount),
        .track_o    (cur_track),
        .pos_o      (cur_pos),
        .addr_o     (cur_addr),
        .last_o     (last_word),
        .overflow_o (overflow)
    );

    // Control FSM: next state and state-decoded bus strobes/addresses.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        error_d      = error_q;
        load         = 1'b0;
        step         = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        hdTrack      = '0;
        hdTrackPos   = '0;
        hdWriteData  = '0;
        hdFlag       = 1'b0;
        memAddr      = '0;
        memWriteData = '0;
        memWrite     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dir_d   = dir;
                    error_d = 1'b0;
                    load    = 1'b1;
                    if (cmdCount == '0) begin
                        state_d = ST_DONE;
                    end else if (cmd_illegal) begin
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SRC_ADDR;
                    end
                end
            end
            ST_SRC_ADDR: begin
                busy = 1'b1;
                if (dir_q == DIR_DISK2MEM) begin
                    hdTrack    = cur_track;
                    hdTrackPos = cur_pos;
                end else begin
                    memAddr    = cur_addr;
                end
                state_d = ST_DST_WRITE;
            end
            ST_DST_WRITE: begin
                busy = 1'b1;
                step = 1'b1;
                if (dir_q == DIR_DISK2MEM) begin
                    memWrite     = 1'b1;
                    memAddr      = cur_addr;
                    memWriteData = hdReadData;
                end else begin
                    hdFlag       = 1'b1;
                    hdTrack      = cur_track;
                    hdTrackPos   = cur_pos;
                    hdWriteData  = memReadData;
                end
                if (last_word) begin
                    state_d = ST_DONE;
                end else if (overflow) begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SRC_ADDR;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, latched direction and sticky error flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_DISK2MEM;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;

endmodule

// File: tb/tb_hd_dma_controller.sv
// Self-checking bench for hd_dma_controller with behavioural disk and
// memory models and a transfer-level reference model.
module tb_hd_dma_controller;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        dir;
    logic [31:0] cmdTrack, cmdPos, cmdMemAddr, cmdCount;
    logic        busy, done, error;
    logic [31:0] hdTrack, hdTrackPos, hdWriteData;
    logic        hdFlag;
    logic [31:0] hdReadData;
    logic [31:0] memAddr, memWriteData;
    logic        memWrite;
    logic [31:0] memReadData;

    logic [31:0] disk [1024];
    logic [31:0] mem  [1024];

    int checks = 0;
    int errors = 0;

    hd_dma_controller dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .dir          (dir),
        .cmdTrack     (cmdTrack),
        .cmdPos       (cmdPos),
        .cmdMemAddr   (cmdMemAddr),
        .cmdCount     (cmdCount),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .hdTrack      (hdTrack),
        .hdTrackPos   (hdTrackPos),
        .hdWriteData  (hdWriteData),
        .hdFlag       (hdFlag),
        .hdReadData   (hdReadData),
        .memAddr      (memAddr),
        .memWriteData (memWriteData),
        .memWrite     (memWrite),
        .memReadData  (memReadData)
    );

    always #5 clock = ~clock;

    function automatic int disk_index(input logic [31:0] t, input logic [31:0] p);
        if (t < 32'd4 && p < 32'd256) return int'(t) * 256 + int'(p);
        return -1;
    endfunction

    // Disk and memory: registered read, synchronous write.
    always @(posedge clock) begin : bus_models
        int di;
        di = disk_index(hdTrack, hdTrackPos);
        hdReadData  <= (di >= 0) ? disk[di] : 32'h0;
        memReadData <= mem[memAddr[11:2]];
        if (hdFlag && di >= 0) disk[di] <= hdWriteData;
        if (memWrite) mem[memAddr[11:2]] <= memWriteData;
    end

    // One command, checked cycle by cycle against the transfer model.
    // poke >= 1 re-asserts start (with random fields) after that sample.
    task automatic run_xfer(input logic d, input logic [31:0] t, input logic [31:0] p,
                            input logic [31:0] a, input logic [31:0] n, input int poke);
        int          m, lin0, avail, bad, i;
        logic        exp_err;
        logic [31:0] disk_snap [1024];
        logic [31:0] mem_snap  [1024];
        logic [4:0]  exp_ctl, obs_ctl;
        logic [31:0] exp_a, exp_b, exp_c;
        lin0 = 0;
        if (n == 0) begin
            m = 0; exp_err = 1'b0;
        end else if (n > 32'd1024 || t >= 32'd4 || p >= 32'd256 || a[1:0] != 2'b00) begin
            m = 0; exp_err = 1'b1;
        end else begin
            lin0    = int'(t) * 256 + int'(p);
            avail   = 1024 - lin0;
            m       = (int'(n) <= avail) ? int'(n) : avail;
            exp_err = int'(n) > avail;
        end
        disk_snap = disk;
        mem_snap  = mem;
        start = 1'b1; dir = d; cmdTrack = t; cmdPos = p; cmdMemAddr = a; cmdCount = n;
        @(posedge clock); #1;
        start = 1'b0; dir = 1'($urandom); cmdTrack = $urandom; cmdPos = $urandom;
        cmdMemAddr = $urandom; cmdCount = $urandom;
        for (int c = 1; c <= 2 * m + 2; c++) begin
            exp_ctl = {c <= 2 * m, c == 2 * m + 1,
                       !d && c % 2 == 0 && c <= 2 * m,
                       d && c % 2 == 0 && c <= 2 * m,
                       exp_err && c >= 2 * m + 1};
            obs_ctl = {busy, done, memWrite, hdFlag, error};
            checks++;
            if (obs_ctl !== exp_ctl) begin
                errors++;
                $display("FAIL ctl c=%0d {busy,done,memWrite,hdFlag,error} got %b exp %b", c, obs_ctl, exp_ctl);
            end
            if (c <= 2 * m) begin
                i = (c - 1) / 2;
                exp_a = a + 32'(4 * i);
                exp_b = 32'((lin0 + i) / 256);
                exp_c = 32'((lin0 + i) % 256);
                if (c % 2 == 0 && !d) begin
                    checks++;
                    if (memAddr !== exp_a || memWriteData !== disk_snap[lin0 + i]) begin
                        errors++;
                        $display("FAIL memwr c=%0d got %h/%h exp %h/%h", c, memAddr, memWriteData, exp_a, disk_snap[lin0 + i]);
                    end
                end else if (c % 2 == 0) begin
                    checks++;
                    if (hdTrack !== exp_b || hdTrackPos !== exp_c ||
                        hdWriteData !== mem_snap[((a >> 2) + 32'(i)) % 1024]) begin
                        errors++;
                        $display("FAIL hdwr c=%0d got %0d/%0d/%h exp %0d/%0d/%h", c, hdTrack, hdTrackPos,
                                 hdWriteData, exp_b, exp_c, mem_snap[((a >> 2) + 32'(i)) % 1024]);
                    end
                end else if (!d) begin
                    checks++;
                    if (hdTrack !== exp_b || hdTrackPos !== exp_c) begin
                        errors++;
                        $display("FAIL hdaddr c=%0d got %0d/%0d exp %0d/%0d", c, hdTrack, hdTrackPos, exp_b, exp_c);
                    end
                end else begin
                    checks++;
                    if (memAddr !== exp_a) begin
                        errors++;
                        $display("FAIL memaddr c=%0d got %h exp %h", c, memAddr, exp_a);
                    end
                end
            end
            if (c == poke) begin
                start = 1'b1; dir = 1'($urandom); cmdTrack = $urandom_range(0, 3);
                cmdPos = $urandom_range(0, 255); cmdMemAddr = $urandom & 32'hFFFF_FFFC;
                cmdCount = $urandom_range(1, 8);
            end else begin
                start = 1'b0;
            end
            if (c < 2 * m + 2) begin
                @(posedge clock); #1;
            end
        end
        bad = 0;
        for (int k = 0; k < m; k++) begin
            if (!d && mem[((a >> 2) + 32'(k)) % 1024] !== disk_snap[lin0 + k]) bad++;
            if (d && disk[lin0 + k] !== mem_snap[((a >> 2) + 32'(k)) % 1024]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL contents dir=%0b got %0d wrong words exp 0", d, bad);
        end
    endtask

    task automatic check_all_zero(input string tag);
        logic [230:0] obs;
        obs = {busy, done, error, hdFlag, memWrite, hdTrack, hdTrackPos, hdWriteData, memAddr, memWriteData};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL %s outputs got %h exp 0", tag, obs);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; dir = 1'b0;
        cmdTrack = '0; cmdPos = '0; cmdMemAddr = '0; cmdCount = '0;
        for (int k = 0; k < 1024; k++) begin
            disk[k] = $urandom;
            mem[k]  = $urandom;
        end
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_disk2mem();
        disk[1 * 256 + 10] = 32'hAAAA_0001;
        disk[1 * 256 + 11] = 32'hBBBB_0002;
        disk[1 * 256 + 12] = 32'hCCCC_0003;
        run_xfer(1'b0, 32'd1, 32'd10, 32'h100, 32'd3, 0);
    endtask

    task automatic test_track_wrap();
        run_xfer(1'b1, 32'd0, 32'd254, 32'h200, 32'd4, 0);
    endtask

    task automatic test_overflow();
        run_xfer(1'b0, 32'd3, 32'd255, 32'h300, 32'd2, 0);
        run_xfer(1'b1, 32'd3, 32'd250, 32'h400, 32'd6, 0);
        run_xfer(1'b1, 32'd3, 32'd250, 32'h400, 32'd9, 0);
    endtask

    task automatic test_illegal();
        run_xfer(1'b0, 32'd0, 32'd0, 32'h0, 32'd0, 0);
        run_xfer(1'b0, 32'd4, 32'd0, 32'h0, 32'd2, 0);
        run_xfer(1'b1, 32'd0, 32'd256, 32'h0, 32'd2, 0);
        run_xfer(1'b0, 32'd0, 32'd0, 32'h102, 32'd2, 0);
        run_xfer(1'b1, 32'd0, 32'd0, 32'h0, 32'd1025, 0);
        run_xfer(1'b0, 32'd2, 32'd5, 32'h0, 32'd1, 0);
    endtask

    task automatic test_full_disk();
        run_xfer(1'b1, 32'd0, 32'd0, 32'h0, 32'd1024, 0);
    endtask

    task automatic test_start_while_busy();
        run_xfer(1'b0, 32'd2, 32'd100, 32'h500, 32'd5, 4);
        run_xfer(1'b1, 32'd1, 32'd7, 32'h600, 32'd3, 7);
    endtask

    task automatic test_back_to_back();
        run_xfer(1'b0, 32'd0, 32'd20, 32'hFFFF_FFF8, 32'd4, 0);
        run_xfer(1'b1, 32'd2, 32'd255, 32'h40, 32'd2, 0);
    endtask

    task automatic test_reset_mid();
        start = 1'b1; dir = 1'b0; cmdTrack = 32'd1; cmdPos = 32'd50;
        cmdMemAddr = 32'h700; cmdCount = 32'd5;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        run_xfer(1'b1, 32'd1, 32'd50, 32'h700, 32'd5, 0);
    endtask

    task automatic test_random();
        logic [31:0] t, p, a, n;
        for (int r = 0; r < 30; r++) begin
            t = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0:       p = $urandom_range(248, 255);
                1:       p = ($urandom_range(0, 5) == 0) ? $urandom_range(256, 300) : $urandom_range(0, 255);
                default: p = $urandom_range(0, 255);
            endcase
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            n = ($urandom_range(0, 15) == 0) ? $urandom_range(1025, 2000) : $urandom_range(0, 12);
            run_xfer(1'($urandom), t, p, a, n, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0);
        end
    endtask

    initial begin
        test_reset();
        test_disk2mem();
        test_track_wrap();
        test_overflow();
        test_illegal();
        test_start_while_busy();
        test_back_to_back();
        test_full_disk();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
